// File: rtl/trading_pkg.sv
// Shared types and constants for the trading pipeline stages.
// Price samples are unsigned 8-bit; squared prices need the full 16 bits.
package trading_pkg;

  typedef logic [7:0]  price_t;
  typedef logic [15:0] price_sq_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

  localparam int DEFAULT_LOG2_N = 3;

endpackage

// File: rtl/rolling_window_stats_ring_buffer.sv
// Circular store of the last 2^LOG2_N price samples. The entry about to be
// overwritten is presented combinationally so the running sums can evict it.
module sample_ring_buffer
  import trading_pkg::*;
#(
  parameter int LOG2_N = DEFAULT_LOG2_N
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   wr_en,
  input  price_t wr_data,
  output price_t old_data
);

  localparam int DEPTH = 1 << LOG2_N;

  price_t            mem [DEPTH];
  logic [LOG2_N-1:0] wr_ptr;

  // Zeroed entries let the fill phase share the sliding update rule.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + LOG2_N'(1);
    end
  end

  assign old_data = mem[wr_ptr];

endmodule

// File: rtl/rolling_window_stats.sv
// Sliding-window mean and mean-of-squares over the last 2^LOG2_N samples,
// feeding the Z-score stage with a one-cycle strobe per complete window.
module rolling_window_stats
  import trading_pkg::*;
#(
  parameter int LOG2_N = DEFAULT_LOG2_N
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  input  logic        clear,
  output logic [7:0]  N_mean,
  output logic [15:0] N_sqr_mean,
  output logic [7:0]  current_data,
  output logic        data_valid_pre,
  output logic        window_full
);

  localparam int SUM_W = 8 + LOG2_N;
  localparam int SQ_W  = 16 + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  win_state_t        state;
  logic [LOG2_N-1:0] fill_cnt;
  logic [SUM_W-1:0]  sum;
  logic [SQ_W-1:0]   sqsum;

  price_t            old_sample;
  price_sq_t         new_sq;
  price_sq_t         old_sq;
  logic [SUM_W-1:0]  sum_next;
  logic [SQ_W-1:0]   sqsum_next;
  logic              fills_window;

  sample_ring_buffer #(
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .wr_en    (data_valid_in && !clear),
    .wr_data  (data_in),
    .old_data (old_sample)
  );

  // Sums can never go negative: the evicted sample is always part of them.
  always_comb begin
    new_sq       = price_sq_t'(data_in) * price_sq_t'(data_in);
    old_sq       = price_sq_t'(old_sample) * price_sq_t'(old_sample);
    sum_next     = sum + SUM_W'(data_in) - SUM_W'(old_sample);
    sqsum_next   = sqsum + SQ_W'(new_sq) - SQ_W'(old_sq);
    fills_window = (state == RUN) || (fill_cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      fill_cnt       <= '0;
      sum            <= '0;
      sqsum          <= '0;
      N_mean         <= '0;
      N_sqr_mean     <= '0;
      current_data   <= '0;
      data_valid_pre <= 1'b0;
      window_full    <= 1'b0;
    end else if (clear) begin
      state          <= FILL;
      fill_cnt       <= '0;
      sum            <= '0;
      sqsum          <= '0;
      data_valid_pre <= 1'b0;
      window_full    <= 1'b0;
    end else if (data_valid_in) begin
      sum          <= sum_next;
      sqsum        <= sqsum_next;
      N_mean       <= sum_next[SUM_W-1:LOG2_N];
      N_sqr_mean   <= sqsum_next[SQ_W-1:LOG2_N];
      current_data <= data_in;
      data_valid_pre <= fills_window;
      if (state == FILL) begin
        fill_cnt <= fill_cnt + LOG2_N'(1);
        if (fill_cnt == CNT_LAST) begin
          state       <= RUN;
          window_full <= 1'b1;
        end
      end
    end else begin
      data_valid_pre <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rolling_window_stats.sv
// Randomised and directed bench for rolling_window_stats, checked against a
// queue-based model of the sliding window.
module tb_rolling_window_stats;

  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid_in = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  N_mean;
  logic [15:0] N_sqr_mean;
  logic [7:0]  current_data;
  logic        data_valid_pre;
  logic        window_full;

  int n_checks = 0;
  int n_fail   = 0;

  int          win[$];
  logic [7:0]  exp_mean = '0;
  logic [15:0] exp_sq = '0;
  logic [7:0]  exp_cur = '0;
  logic        exp_valid = 1'b0;
  logic        exp_full = 1'b0;

  rolling_window_stats #(.LOG2_N(LOG2_N)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .clear          (clear),
    .N_mean         (N_mean),
    .N_sqr_mean     (N_sqr_mean),
    .current_data   (current_data),
    .data_valid_pre (data_valid_pre),
    .window_full    (window_full)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] obs_vec();
    return {N_mean, N_sqr_mean, current_data, data_valid_pre, window_full};
  endfunction

  function automatic logic [33:0] exp_vec();
    return {exp_mean, exp_sq, exp_cur, exp_valid, exp_full};
  endfunction

  // One clock of stimulus; the model applies the window rules from scratch.
  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    int s, q;
    @(negedge clk);
    data_valid_in = v;
    data_in       = d;
    clear         = c;
    @(posedge clk);
    #1;
    data_valid_in = 1'b0;
    clear         = 1'b0;
    if (c) begin
      win.delete();
      exp_valid = 1'b0;
    end else if (v) begin
      win.push_back(int'(d));
      if (win.size() > N) void'(win.pop_front());
      s = 0;
      q = 0;
      foreach (win[i]) begin
        s += win[i];
        q += win[i] * win[i];
      end
      exp_mean  = 8'(s / N);
      exp_sq    = 16'(q / N);
      exp_cur   = d;
      exp_valid = (win.size() == N);
    end else begin
      exp_valid = 1'b0;
    end
    exp_full = (win.size() == N);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    data_valid_in = 1'b1;
    data_in       = 8'd99;
    clear         = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    data_valid_in = 1'b0;
    win.delete();
    exp_mean  = '0;
    exp_sq    = '0;
    exp_cur   = '0;
    exp_valid = 1'b0;
    exp_full  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_vec() !== 34'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h want %h", obs_vec(), 34'd0);
    end
  endtask

  task automatic test_warmup();
    for (int i = 0; i < N - 1; i++) begin
      drive(1'b1, 8'd10, 1'b0);
      n_checks++;
      if (data_valid_pre !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL warmup_fill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    drive(1'b1, 8'd10, 1'b0);
    n_checks++;
    if (obs_vec() !== {8'd10, 16'd100, 8'd10, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL warmup_first_strobe: got %h want %h", obs_vec(),
               {8'd10, 16'd100, 8'd10, 1'b1, 1'b1});
    end
  endtask

  task automatic test_slide();
    drive(1'b1, 8'd18, 1'b0);
    n_checks++;
    if (obs_vec() !== {8'd11, 16'd128, 8'd18, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL slide_first: got %h want %h", obs_vec(),
               {8'd11, 16'd128, 8'd18, 1'b1, 1'b1});
    end
    for (int i = 0; i < N - 1; i++) drive(1'b1, 8'd18, 1'b0);
    n_checks++;
    if (obs_vec() !== {8'd18, 16'd324, 8'd18, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL slide_full: got %h want %h", obs_vec(),
               {8'd18, 16'd324, 8'd18, 1'b1, 1'b1});
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < N; i++) drive(1'b1, 8'd255, 1'b0);
    n_checks++;
    if (obs_vec() !== {8'd255, 16'd65025, 8'd255, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL extreme_max: got %h want %h", obs_vec(),
               {8'd255, 16'd65025, 8'd255, 1'b1, 1'b1});
    end
    for (int i = 0; i < N; i++) drive(1'b1, 8'd0, 1'b0);
    n_checks++;
    if (obs_vec() !== {8'd0, 16'd0, 8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL extreme_zero: got %h want %h", obs_vec(),
               {8'd0, 16'd0, 8'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < N; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL gap_hold[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL gap_resume[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < N; i++) drive(1'b1, 8'd50, 1'b0);
    drive(1'b1, 8'd200, 1'b1);
    n_checks++;
    if (data_valid_pre !== 1'b0 || window_full !== 1'b0 || current_data !== 8'd50) begin
      n_fail++;
      $display("[TB] FAIL clear_drop: got valid=%b full=%b cur=%0d want 0 0 50",
               data_valid_pre, window_full, current_data);
    end
    for (int i = 0; i < N - 1; i++) begin
      drive(1'b1, 8'd4, 1'b0);
      n_checks++;
      if (data_valid_pre !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL clear_refill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    drive(1'b1, 8'd4, 1'b0);
    n_checks++;
    if (obs_vec() !== {8'd4, 16'd16, 8'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL clear_strobe: got %h want %h", obs_vec(),
               {8'd4, 16'd16, 8'd4, 1'b1, 1'b1});
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < N + 3; i++) drive(1'b1, 8'($urandom_range(1, 255)), 1'b0);
    do_reset();
    n_checks++;
    if (obs_vec() !== 34'd0) begin
      n_fail++;
      $display("[TB] FAIL midstream_reset: got %h want %h", obs_vec(), 34'd0);
    end
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL midstream_warmup[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic v, c;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 199) == 0);
      drive(v, 8'($urandom_range(0, 255)), c);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (data_valid_pre === 1'b1) begin
        n_checks++;
        if (int'(N_sqr_mean) < int'(N_mean) * int'(N_mean)) begin
          n_fail++;
          $display("[TB] FAIL sq_ge_mean2[%0d]: got sq=%0d mean=%0d want sq>=mean^2",
                   i, N_sqr_mean, N_mean);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_slide();
    test_extremes();
    test_gaps();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
